// File: rtl/extremum_finder.sv
// Streaming min/max search over a start-delimited window of tagged samples.
// Reports the extreme value, its index tag and the window's sample count.
module extremum_finder #(
  parameter int DATA_W   = 36,
  parameter int IDX_W    = 13,
  parameter int FIND_MAX = 0,
  parameter int TIE_LAST = 0,
  parameter int WIN_LEN  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              en,
  input  logic              last,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] inp,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ext_val,
  output logic [IDX_W-1:0]  ext_loc,
  output logic [IDX_W-1:0]  smp_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_best;
  logic [IDX_W-1:0]  r_best_idx;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_have;
  logic [DATA_W-1:0] r_ext_val;
  logic [IDX_W-1:0]  r_ext_loc;
  logic [IDX_W-1:0]  r_smp_cnt;

  logic              w_accept;
  logic              w_better;
  logic              w_take;
  logic [DATA_W-1:0] w_best_val;
  logic [IDX_W-1:0]  w_best_idx;
  logic [IDX_W-1:0]  w_cnt_next;
  logic              w_win_hit;
  logic              w_close;

  // A start in SEARCH restarts the window, so that cycle's sample is never accepted.
  assign w_accept = (r_state == S_SEARCH) && !start && en;

  always_comb begin
    w_better = 1'b0;
    if (FIND_MAX != 0) begin
      w_better = (TIE_LAST != 0) ? (inp >= r_best) : (inp > r_best);
    end else begin
      w_better = (TIE_LAST != 0) ? (inp <= r_best) : (inp < r_best);
    end
  end

  assign w_take     = !r_have || w_better;
  assign w_best_val = w_take ? inp : r_best;
  assign w_best_idx = w_take ? idx : r_best_idx;
  assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_win_hit  = (WIN_LEN > 0) && (int'(w_cnt_next) == WIN_LEN);
  assign w_close    = w_accept && (last || w_win_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_best     <= '0;
      r_best_idx <= '0;
      r_cnt      <= '0;
      r_have     <= 1'b0;
      r_ext_val  <= '0;
      r_ext_loc  <= '0;
      r_smp_cnt  <= '0;
    end else if (start) begin
      r_state    <= S_SEARCH;
      r_best     <= '0;
      r_best_idx <= '0;
      r_cnt      <= '0;
      r_have     <= 1'b0;
    end else begin
      case (r_state)
        S_SEARCH: begin
          if (w_accept) begin
            r_best     <= w_best_val;
            r_best_idx <= w_best_idx;
            r_cnt      <= w_cnt_next;
            r_have     <= 1'b1;
          end
          if (w_close) begin
            r_ext_val <= w_best_val;
            r_ext_loc <= w_best_idx;
            r_smp_cnt <= w_cnt_next;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == S_SEARCH);
  assign done    = (r_state == S_DONE);
  assign ext_val = r_ext_val;
  assign ext_loc = r_ext_loc;
  assign smp_cnt = r_smp_cnt;

endmodule

// File: tb/tb_extremum_finder.sv
// Scoreboard bench for extremum_finder: three parameterisations share one stimulus
// stream; a window-list reference model predicts each result, a monitor checks it.
module tb_extremum_finder;

  localparam int NDUT = 3;
  localparam int P_MAX [NDUT] = '{0, 0, 1};
  localparam int P_TIE [NDUT] = '{0, 1, 1};
  localparam int P_WL  [NDUT] = '{0, 0, 4};

  typedef struct {
    logic [35:0] v;
    logic [12:0] i;
  } smp_t;

  typedef struct {
    logic [35:0] v;
    logic [12:0] l;
    logic [12:0] c;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, en, last;
  logic [12:0] idx;
  logic [35:0] inp;

  logic [NDUT-1:0] busy_w, done_w;
  logic [35:0]     val_w [NDUT];
  logic [12:0]     loc_w [NDUT];
  logic [12:0]     cnt_w [NDUT];

  int tests_run = 0;
  int tests_failed = 0;

  smp_t win   [NDUT][$];
  res_t expq  [NDUT][$];
  res_t held  [NDUT];
  bit   open  [NDUT];
  bit   closed_now [NDUT];

  always #5 clk = ~clk;

  extremum_finder #(.FIND_MAX(0), .TIE_LAST(0), .WIN_LEN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .last(last), .idx(idx), .inp(inp),
    .busy(busy_w[0]), .done(done_w[0]), .ext_val(val_w[0]), .ext_loc(loc_w[0]), .smp_cnt(cnt_w[0]));
  extremum_finder #(.FIND_MAX(0), .TIE_LAST(1), .WIN_LEN(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .last(last), .idx(idx), .inp(inp),
    .busy(busy_w[1]), .done(done_w[1]), .ext_val(val_w[1]), .ext_loc(loc_w[1]), .smp_cnt(cnt_w[1]));
  extremum_finder #(.FIND_MAX(1), .TIE_LAST(1), .WIN_LEN(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .last(last), .idx(idx), .inp(inp),
    .busy(busy_w[2]), .done(done_w[2]), .ext_val(val_w[2]), .ext_loc(loc_w[2]), .smp_cnt(cnt_w[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Extreme value first, then the first/last position holding it.
  function automatic res_t reduce(input int k);
    res_t r;
    logic [35:0] e;
    bit found;
    e = win[k][0].v;
    foreach (win[k][j]) begin
      if (P_MAX[k] != 0) begin
        if (win[k][j].v > e) e = win[k][j].v;
      end else begin
        if (win[k][j].v < e) e = win[k][j].v;
      end
    end
    found = 0;
    r.v = e;
    r.l = '0;
    foreach (win[k][j]) begin
      if (win[k][j].v == e && (P_TIE[k] != 0 || !found)) begin
        r.l = win[k][j].i;
        found = 1;
      end
    end
    r.c = (win[k].size() > 8191) ? 13'd8191 : 13'(win[k].size());
    return r;
  endfunction

  task automatic model_step(input int k, input bit s, input bit e, input bit l,
                            input logic [12:0] i, input logic [35:0] v);
    smp_t sm;
    res_t r;
    closed_now[k] = 0;
    if (s) begin
      open[k] = 1;
      win[k].delete();
    end else if (open[k] && e) begin
      sm.v = v;
      sm.i = i;
      win[k].push_back(sm);
      if (l || (P_WL[k] > 0 && win[k].size() == P_WL[k])) begin
        r = reduce(k);
        expq[k].push_back(r);
        held[k] = r;
        open[k] = 0;
        closed_now[k] = 1;
      end
    end
  endtask

  task automatic cyc(input bit s, input bit e, input bit l, input logic [12:0] i, input logic [35:0] v);
    start = s; en = e; last = l; idx = i; inp = v;
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) model_step(k, s, e, l, i, v);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      open[k] = 0;
      closed_now[k] = 0;
      win[k].delete();
      expq[k].delete();
      held[k] = '{v: '0, l: '0, c: '0};
    end
  endtask

  task automatic async_reset();
    start = 0; en = 0; last = 0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_busy[%0d]", k), 64'(busy_w[k]), 64'(0));
      chk($sformatf("rst_done[%0d]", k), 64'(done_w[k]), 64'(0));
      chk($sformatf("rst_val[%0d]", k), 64'(val_w[k]), 64'(0));
      chk($sformatf("rst_loc[%0d]", k), 64'(loc_w[k]), 64'(0));
      chk($sformatf("rst_cnt[%0d]", k), 64'(cnt_w[k]), 64'(0));
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: done pops the scoreboard; busy, done timing and held results checked every cycle.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      res_t r;
      chk($sformatf("busy[%0d]", k), 64'(busy_w[k]), 64'(open[k]));
      chk($sformatf("done_timing[%0d]", k), 64'(done_w[k]), 64'(closed_now[k]));
      if (done_w[k]) begin
        if (expq[k].size() == 0) begin
          chk($sformatf("unexpected_done[%0d]", k), 64'(1), 64'(0));
        end else begin
          r = expq[k].pop_front();
          chk($sformatf("ext_val[%0d]", k), 64'(val_w[k]), 64'(r.v));
          chk($sformatf("ext_loc[%0d]", k), 64'(loc_w[k]), 64'(r.l));
          chk($sformatf("smp_cnt[%0d]", k), 64'(cnt_w[k]), 64'(r.c));
          $display("[TB] dut%0d window: val=0x%0h loc=%0d cnt=%0d", k, val_w[k], loc_w[k], cnt_w[k]);
        end
      end
      chk($sformatf("hold[%0d]", k), {val_w[k], loc_w[k], 15'd0}, {held[k].v, held[k].l, 15'd0});
      chk($sformatf("hold_cnt[%0d]", k), 64'(cnt_w[k]), 64'(held[k].c));
    end
  end

  initial begin
    logic [35:0] v;
    int r;
    model_reset();
    rst_n = 1'b0; start = 0; en = 0; last = 0; idx = '0; inp = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 1, 13'd7, 36'd1);   // ignored while idle

    // 5,3,7,3 with last on idx 3
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 36'd5);
    cyc(0, 1, 0, 1, 36'd3);
    cyc(0, 1, 0, 2, 36'd7);
    cyc(0, 1, 1, 3, 36'd3);
    cyc(0, 0, 0, 0, 0);
    chk("d033_val", 64'(val_w[0]), 64'(3));
    chk("d033_loc", 64'(loc_w[0]), 64'(1));
    chk("d033_cnt", 64'(cnt_w[0]), 64'(4));
    chk("d034_val", 64'(val_w[1]), 64'(3));
    chk("d034_loc", 64'(loc_w[1]), 64'(3));
    chk("d034_cnt", 64'(cnt_w[1]), 64'(4));

    // Extremes of the 36-bit range
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 8, 36'h0);
    cyc(0, 1, 1, 9, 36'hF_FFFF_FFFF);
    cyc(0, 0, 0, 0, 0);
    chk("d035_max_val", 64'(val_w[2]), 64'h0000_000F_FFFF_FFFF);
    chk("d035_max_loc", 64'(loc_w[2]), 64'(9));
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 5, 36'hF_FFFF_FFFF);
    cyc(0, 0, 0, 0, 0);
    chk("d035_min_val", 64'(val_w[0]), 64'h0000_000F_FFFF_FFFF);
    chk("d035_min_loc", 64'(loc_w[0]), 64'(5));

    // Auto-close window with en gaps, trailing samples ignored by the WIN_LEN instance
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 36'd9);
    cyc(0, 0, 0, 0, 36'd0);
    cyc(0, 1, 0, 1, 36'd8);
    cyc(0, 1, 0, 2, 36'd7);
    cyc(0, 0, 0, 0, 36'd0);
    cyc(0, 1, 0, 3, 36'd6);
    cyc(0, 1, 0, 4, 36'd1);
    cyc(0, 0, 0, 0, 36'd0);
    cyc(0, 1, 0, 5, 36'd0);
    cyc(0, 0, 0, 0, 0);
    chk("d036_cnt", 64'(cnt_w[2]), 64'(4));

    // Restart mid-window
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 36'd1);
    cyc(0, 1, 0, 1, 36'd0);
    cyc(1, 1, 0, 2, 36'd0);
    cyc(0, 1, 0, 3, 36'd4);
    cyc(0, 1, 1, 4, 36'd2);
    cyc(0, 0, 0, 0, 0);
    chk("d037_val", 64'(val_w[0]), 64'(2));
    chk("d037_cnt", 64'(cnt_w[0]), 64'(2));

    // Reset mid-search
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 36'd11);
    cyc(0, 1, 0, 1, 36'd12);
    async_reset();
    repeat (3) cyc(0, 1, 1, 2, 36'd3);

    // Count saturation
    cyc(1, 0, 0, 0, 0);
    for (int n = 0; n < 8200; n++) cyc(0, 1, 0, 13'(n), 36'(n % 97 + 10));
    cyc(0, 1, 1, 13'd42, 36'd50);
    cyc(0, 0, 0, 0, 0);
    chk("sat_cnt", 64'(cnt_w[0]), 64'(8191));

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 3));
      v = (r == 0) ? 36'({$urandom, $urandom}) : 36'($urandom_range(0, 7));
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
          13'($urandom), v);
      if (n == 2500) async_reset();
    end
    repeat (4) cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("pending_results[%0d]", k), 64'(expq[k].size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/extremum_finder.md
EXTREMUM_FINDER -- requirements
Module: extremum_finder

Interface
REQ-001 SHALL have parameter DATA_W, default 36, sample width (unsigned).
REQ-002 SHALL have parameter IDX_W, default 13, index and sample-count width.
REQ-003 SHALL have parameter FIND_MAX, default 0; 0 = search for minimum, 1 = search for maximum.
REQ-004 SHALL have parameter TIE_LAST, default 0; 0 = keep first occurrence of equal extremes, 1 = keep last.
REQ-005 SHALL have parameter WIN_LEN, default 0; 0 = window closed only by last, N>0 = window also auto-closes at the Nth accepted sample.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, opens a new search window.
REQ-009 SHALL have port en, input, 1, sample valid.
REQ-010 SHALL have port last, input, 1, qualified by en, marks final sample of window.
REQ-011 SHALL have port idx, input, IDX_W, index tag of current sample.
REQ-012 SHALL have port inp, input, DATA_W, sample value.
REQ-013 SHALL have port busy, output, 1, high while a window is open.
REQ-014 SHALL have port done, output, 1, one-cycle result strobe.
REQ-015 SHALL have port ext_val, output, DATA_W, extreme value of last completed window.
REQ-016 SHALL have port ext_loc, output, IDX_W, idx of that extreme.
REQ-017 SHALL have port smp_cnt, output, IDX_W, number of samples accepted in last completed window.

Function
REQ-018 SHALL implement states IDLE, SEARCH, DONE; busy = (state==SEARCH); done = (state==DONE).
REQ-019 In IDLE or DONE, start=1 SHALL enter SEARCH at next edge, clearing running best, running count to 0 and have-sample flag.
REQ-020 In IDLE/DONE, en, last, idx, inp SHALL be ignored when start=0.
REQ-021 In SEARCH, start=1 SHALL restart the window (clear as REQ-019), discard that cycle's sample, produce no done, and leave result outputs unchanged.
REQ-022 In SEARCH with en=1, the first sample of the window SHALL always become the running best regardless of value.
REQ-023 Subsequent samples SHALL replace the best when: min mode inp<best (TIE_LAST=0) or inp<=best (TIE_LAST=1); max mode inp>best or inp>=best respectively; comparison unsigned, full DATA_W.
REQ-024 Running count SHALL increment per accepted sample and saturate at 2^IDX_W-1.
REQ-025 Window SHALL close on an accepted sample with last=1, or (WIN_LEN>0) on the sample bringing count to WIN_LEN; the closing sample SHALL be included in the compare and count.
REQ-026 On the closing edge, ext_val, ext_loc, smp_cnt SHALL load the final best (including the closing sample) and state SHALL go to DONE.
REQ-027 done SHALL be high exactly one cycle, the cycle after the closing sample; DONE SHALL return to IDLE next edge unless start=1 (then SEARCH).
REQ-028 Result outputs SHALL hold their values until the next closing edge.
REQ-029 Samples arriving after auto-close and before a new start SHALL be ignored.
REQ-030 en gaps in SEARCH SHALL hold all state; window length is unbounded when WIN_LEN=0.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, ext_val=0, ext_loc=0, smp_cnt=0, running best and count to 0, including mid-SEARCH; no done after release.
REQ-032 After rst_n rises, the block SHALL wait for start.

Verification
REQ-033 Min, TIE_LAST=0: start; samples 5,3,7,3 at idx 0..3, last on idx 3 -> next cycle done=1 one cycle, ext_val=3, ext_loc=1, smp_cnt=4.
REQ-034 Same stimulus with TIE_LAST=1 -> ext_val=3, ext_loc=3, smp_cnt=4.
REQ-035 FIND_MAX=1: samples 0x0 (idx 8), 0xFFFFFFFFF (idx 9, last) -> ext_val=0xFFFFFFFFF, ext_loc=9; min mode single sample 0xFFFFFFFFF idx 5 last -> ext_val=0xFFFFFFFFF, ext_loc=5.
REQ-036 WIN_LEN=4, no last: six samples 9,8,7,6,1,0 with en gaps -> done after 4th, ext_val=6, ext_loc=3, smp_cnt=4; samples 1,0 ignored.
REQ-037 start reasserted after two samples in SEARCH -> no done; new window 4,2(last) -> ext_val=2, smp_cnt=2.
REQ-038 rst_n low mid-SEARCH -> all outputs 0 asynchronously, busy=0, no done after release until a new window closes.
